// File: rtl/stream_mux_pkt_if.sv
//------------------------------------------------------------------------------
// stream_mux_pkt_if
//
// Bundles every stream and status signal of stream_mux_pkt. Clock and reset
// stay plain ports on the module.
//
// Parameters:
//   DATA_T  payload type of every input stream and of the output stream
//   N_INP   number of input streams (>= 1)
//   SEL_W   select width, derived from N_INP (not a parameter)
//
// Signals (direction seen from the multiplexer, i.e. the slave modport):
//   inp_data_i  [N_INP] in   input payloads
//   inp_last_i  [N_INP] in   end-of-packet flag per input
//   inp_valid_i [N_INP] in   input valids
//   inp_ready_o [N_INP] out  input readies
//   inp_sel_i   [SEL_W] in   requested input
//   oup_data_o          out  output payload
//   oup_last_o          out  output end-of-packet
//   oup_valid_o         out  output valid
//   oup_ready_i         in   output ready
//   locked_o            out  packet in progress, selection frozen
//   lock_sel_o  [SEL_W] out  locked input, 0 when not locked
//   err_o               out  sticky out-of-range select flag
//
// Modports:
//   master  the side that feeds the inputs and consumes the output
//   slave   the multiplexer itself
//------------------------------------------------------------------------------
`timescale 1ns/1ps

interface stream_mux_pkt_if #(
  parameter type         DATA_T = logic,
  parameter int unsigned N_INP  = 1
);

  localparam int unsigned SEL_W = (N_INP > 1) ? $clog2(N_INP) : 1;

  DATA_T              inp_data_i [N_INP];
  logic [N_INP-1:0]   inp_last_i;
  logic [N_INP-1:0]   inp_valid_i;
  logic [N_INP-1:0]   inp_ready_o;
  logic [SEL_W-1:0]   inp_sel_i;

  DATA_T              oup_data_o;
  logic               oup_last_o;
  logic               oup_valid_o;
  logic               oup_ready_i;

  logic               locked_o;
  logic [SEL_W-1:0]   lock_sel_o;
  logic               err_o;

  modport master (
    output inp_data_i,
    output inp_last_i,
    output inp_valid_i,
    input  inp_ready_o,
    output inp_sel_i,
    input  oup_data_o,
    input  oup_last_o,
    input  oup_valid_o,
    output oup_ready_i,
    input  locked_o,
    input  lock_sel_o,
    input  err_o
  );

  modport slave (
    input  inp_data_i,
    input  inp_last_i,
    input  inp_valid_i,
    output inp_ready_o,
    input  inp_sel_i,
    output oup_data_o,
    output oup_last_o,
    output oup_valid_o,
    input  oup_ready_i,
    output locked_o,
    output lock_sel_o,
    output err_o
  );

endinterface : stream_mux_pkt_if

// File: rtl/stream_mux_pkt.sv
//------------------------------------------------------------------------------
// stream_mux_pkt
//
// Packet-aware stream multiplexer. Connects one of N_INP valid/ready input
// streams to a single output. Once the first beat of a packet is accepted the
// selection is frozen until the beat carrying last, so beats of different
// packets never interleave on the output. An optional output register cuts the
// forward path while keeping one beat per cycle.
//
// Parameters:
//   DATA_T    payload type (must match the interface instance)
//   N_INP     number of input streams, must be >= 1 (match the interface)
//   LOCK_PKT  1: hold the selection for a whole packet, 0: per-beat select
//   OUT_REG   1: registered output stage, 0: combinational path
//
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     stream_mux_pkt_if.slave, all stream and status signals
//
// Optional feature (compile-time macro STREAM_MUX_PKT_SEL_ERR_EN):
//   defined   err_o is a sticky flag, set on any edge where the block is idle
//             and inp_sel_i addresses a non-existent input; cleared by reset
//   undefined err_o is tied to 0 and no error register exists
// Out-of-range selects block every input in both builds.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module stream_mux_pkt #(
  parameter type         DATA_T   = logic,
  parameter int unsigned N_INP    = 0,
  parameter int unsigned LOCK_PKT = 1,
  parameter int unsigned OUT_REG  = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  stream_mux_pkt_if.slave   bus
);

  localparam int unsigned SEL_W = (N_INP > 1) ? $clog2(N_INP) : 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]       r_state;
  logic [SEL_W-1:0] r_lock_sel;

  logic [SEL_W-1:0] w_esel;
  logic [31:0]      w_esel_ext;
  logic             w_ird;
  logic             w_hs;
  logic             w_sel_valid;
  logic             w_sel_last;
  DATA_T            w_sel_data;
  logic [N_INP-1:0] w_ready;

  //----------------------------------------------------------------------------
  // Effective select: frozen while a packet is in flight.
  //----------------------------------------------------------------------------
  assign w_esel     = (r_state == ST_LOCKED) ? r_lock_sel : bus.inp_sel_i;
  assign w_esel_ext = 32'(w_esel);

  //----------------------------------------------------------------------------
  // Input selection. The loop only matches existing inputs, so an
  // out-of-range select leaves every ready low and presents no valid beat.
  //----------------------------------------------------------------------------
  // NOTE: every signal written in this always_comb gets a default on entry;
  // without it a path that does not assign would infer a latch.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    w_ready     = '0;
    for (int unsigned i = 0; i < N_INP; i++) begin
      if (w_esel_ext == i) begin
        w_sel_valid = bus.inp_valid_i[i];
        w_sel_last  = bus.inp_last_i[i];
        w_sel_data  = bus.inp_data_i[i];
        w_ready[i]  = w_ird;
      end
    end
  end

  assign bus.inp_ready_o = w_ready;
  assign w_hs            = w_sel_valid & w_ird;

  //----------------------------------------------------------------------------
  // Packet lock FSM. The first beat is accepted in IDLE with the live select;
  // the captured select only steers from the following cycle. A single-beat
  // packet never leaves IDLE, so back-to-back packets see no bubble.
  //----------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_lock_sel <= '0;
    end else if ((LOCK_PKT != 0) && w_hs) begin
      if (r_state == ST_IDLE) begin
        if (!w_sel_last) begin
          r_state    <= ST_LOCKED;
          r_lock_sel <= bus.inp_sel_i;
        end
      end else begin
        if (w_sel_last) begin
          r_state    <= ST_IDLE;
          r_lock_sel <= '0;
        end
      end
    end
  end

  assign bus.locked_o   = (r_state == ST_LOCKED);
  assign bus.lock_sel_o = r_lock_sel;

  //----------------------------------------------------------------------------
  // Output stage.
  //----------------------------------------------------------------------------
  if (OUT_REG != 0) begin : g_out_reg
    logic  r_valid;
    logic  r_last;
    DATA_T r_data;

    // The register can take a new beat when it is empty or being drained this
    // cycle, which gives full throughput with a single entry.
    assign w_ird = ~r_valid | bus.oup_ready_i;

    // NOTE: the payload register is reset too; it is a single word, and a
    // defined zero output after reset is part of the contract. Deep storage
    // arrays would normally be left unreset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_data  <= '0;
      end else if (w_hs) begin
        r_valid <= 1'b1;
        r_last  <= w_sel_last;
        r_data  <= w_sel_data;
      end else if (bus.oup_ready_i) begin
        r_valid <= 1'b0;
      end
    end

    assign bus.oup_valid_o = r_valid;
    assign bus.oup_last_o  = r_last;
    assign bus.oup_data_o  = r_data;
  end else begin : g_out_comb
    assign w_ird           = bus.oup_ready_i;
    assign bus.oup_valid_o = w_sel_valid;
    assign bus.oup_last_o  = w_sel_last;
    assign bus.oup_data_o  = w_sel_data;
  end

  //----------------------------------------------------------------------------
  // Out-of-range select error flag.
  //----------------------------------------------------------------------------
`ifdef STREAM_MUX_PKT_SEL_ERR_EN
  logic r_err;
  logic w_req_bad;

  // Only checked while idle: in LOCKED the requested select is ignored.
  assign w_req_bad = (32'(bus.inp_sel_i) >= N_INP);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_req_bad) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err_o = r_err;
`else
  assign bus.err_o = 1'b0;
`endif

  //----------------------------------------------------------------------------
  // A zero-input multiplexer is meaningless; flag it in simulation.
  //----------------------------------------------------------------------------
`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    assert (N_INP >= 1) else $error("stream_mux_pkt: N_INP must be >= 1");
  end
`endif

endmodule : stream_mux_pkt

// File: tb/tb_stream_mux_pkt.sv
//------------------------------------------------------------------------------
// tb_stream_mux_pkt
//
// Bench for stream_mux_pkt. The main instance (4 inputs, packet lock, output
// register) is compared on every cycle against a model that tracks only the
// packet owner (which input holds the lock, or none) and the queue of beats
// accepted but not yet delivered. A second instance with 3 inputs exercises
// the out-of-range select. Directed sequences pin the model with hand-computed
// values; a randomized run then covers the general traffic.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_stream_mux_pkt;

  typedef logic [7:0] data_t;

  typedef struct {
    data_t d;
    logic  l;
  } beat_t;

`ifdef STREAM_MUX_PKT_SEL_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk;
  logic rst_n;

  stream_mux_pkt_if #(.DATA_T(data_t), .N_INP(4)) b4 ();
  stream_mux_pkt_if #(.DATA_T(data_t), .N_INP(3)) b3 ();

  stream_mux_pkt #(
    .DATA_T(data_t), .N_INP(4), .LOCK_PKT(1), .OUT_REG(1)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (b4)
  );

  stream_mux_pkt #(
    .DATA_T(data_t), .N_INP(3), .LOCK_PKT(1), .OUT_REG(1)
  ) dut3 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state.
  int    owner = -1;    // input holding the packet lock, -1 when none
  beat_t q[$];          // accepted beats not yet delivered
  bit    m_hs;          // a beat was accepted on the last edge
  int    cyc = 0;

  // Delivered beats as seen on the DUT output, with the cycle of delivery.
  beat_t obs[$];
  int    obs_cyc[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int m_esel();
    return (owner >= 0) ? owner : int'(b4.inp_sel_i);
  endfunction

  function automatic bit m_ird();
    return (q.size() == 0) || (b4.oup_ready_i == 1'b1);
  endfunction

  // Per-cycle comparison, taken mid-cycle with inputs settled.
  task automatic compare();
    int   es;
    logic [3:0] er;
    es = m_esel();
    er = m_ird() ? 4'(1 << es) : 4'b0;
    check("ready",    32'(b4.inp_ready_o), 32'(er));
    check("valid",    32'(b4.oup_valid_o), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("data", 32'(b4.oup_data_o), 32'(q[0].d));
      check("last", 32'(b4.oup_last_o), 32'(q[0].l));
    end
    check("locked",   32'(b4.locked_o),   32'(owner >= 0));
    check("lock_sel", 32'(b4.lock_sel_o), (owner >= 0) ? 32'(owner) : 32'd0);
    check("err",      32'(b4.err_o),      32'd0);
    if (b4.oup_valid_o && b4.oup_ready_i) begin
      obs.push_back('{b4.oup_data_o, b4.oup_last_o});
      obs_cyc.push_back(cyc);
    end
  endtask

  // Model advance on the clock edge.
  task automatic model_edge();
    int    es;
    beat_t b;
    es   = m_esel();
    m_hs = m_ird() && (b4.inp_valid_i[es] == 1'b1);
    if ((q.size() != 0) && b4.oup_ready_i) void'(q.pop_front());
    if (m_hs) begin
      b.d = b4.inp_data_i[es];
      b.l = b4.inp_last_i[es];
      q.push_back(b);
      if (owner < 0 && !b.l)       owner = es;
      else if (owner >= 0 && b.l)  owner = -1;
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) b4.inp_data_i[i] = 8'h00;
    b4.inp_last_i  = 4'b0;
    b4.inp_valid_i = 4'b0;
    b4.inp_sel_i   = 2'd0;
  endtask

  task automatic drive_beat(input int idx, input data_t d, input logic l);
    b4.inp_data_i[idx]  = d;
    b4.inp_last_i[idx]  = l;
    b4.inp_valid_i[idx] = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   k;
    int   c0;
    logic pat [4];

    // ---------------- reset ----------------
    rst_n = 1'b0;
    clear_inputs();
    b4.oup_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) b3.inp_data_i[i] = 8'h00;
    b3.inp_last_i  = 3'b0;
    b3.inp_valid_i = 3'b0;
    b3.inp_sel_i   = 2'd0;
    b3.oup_ready_i = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_valid",    32'(b4.oup_valid_o), 32'd0);
    check("rst_data",     32'(b4.oup_data_o),  32'd0);
    check("rst_last",     32'(b4.oup_last_o),  32'd0);
    check("rst_locked",   32'(b4.locked_o),    32'd0);
    check("rst_lock_sel", 32'(b4.lock_sel_o),  32'd0);
    check("rst_err",      32'(b4.err_o),       32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---------------- first beat after reset ----------------
    b4.inp_sel_i = 2'd2;
    drive_beat(2, 8'hA5, 1'b1);
    tick();
    check("first_valid", 32'(b4.oup_valid_o), 32'd1);
    check("first_data",  32'(b4.oup_data_o),  32'hA5);
    clear_inputs();
    tick();

    // ---------------- packet lock ----------------
    b4.inp_sel_i = 2'd1;
    drive_beat(1, 8'h11, 1'b0);
    drive_beat(3, 8'h33, 1'b1);
    tick();
    check("lock_data0", 32'(b4.oup_data_o), 32'h11);
    check("lock_on",    32'(b4.locked_o),   32'd1);
    check("lock_sel1",  32'(b4.lock_sel_o), 32'd1);
    b4.inp_sel_i = 2'd3;
    drive_beat(1, 8'h12, 1'b0);
    #1;
    check("lock_rdy3_blocked", 32'(b4.inp_ready_o[3]), 32'd0);
    tick();
    check("lock_data1", 32'(b4.oup_data_o), 32'h12);
    drive_beat(1, 8'h13, 1'b1);
    tick();
    check("lock_data2", 32'(b4.oup_data_o), 32'h13);
    check("lock_last2", 32'(b4.oup_last_o), 32'd1);
    check("lock_off",   32'(b4.locked_o),   32'd0);
    b4.inp_valid_i[1] = 1'b0;
    tick();
    check("lock_next_in3", 32'(b4.oup_data_o), 32'h33);
    clear_inputs();
    tick();

    // ---------------- backpressure, 4-beat packet ----------------
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    obs.delete(); obs_cyc.delete();
    k = 0;
    for (int c = 0; c < 40 && obs.size() < 4; c++) begin
      clear_inputs();
      if (k < 4) drive_beat(0, data_t'(k), (k == 3));
      b4.oup_ready_i = pat[c % 4];
      tick();
      if (m_hs) k++;
    end
    clear_inputs();
    b4.oup_ready_i = 1'b1;
    repeat (3) tick();
    check("bp_count", 32'(obs.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs.size(); i++)
      check($sformatf("bp_order%0d", i), 32'(obs[i].d), 32'(i));
    if (obs.size() == 4) check("bp_last", 32'(obs[3].l), 32'd1);

    // ---------------- throughput, 16 single-beat packets ----------------
    obs.delete(); obs_cyc.delete();
    c0 = cyc;
    for (int i = 0; i < 18; i++) begin
      clear_inputs();
      if (i < 16) begin
        b4.inp_sel_i = 2'(i % 2);
        drive_beat(i % 2, data_t'(8'h40 + i), 1'b1);
      end
      tick();
    end
    check("tp_count", 32'(obs.size()), 32'd16);
    if (obs.size() == 16) begin
      check("tp_first_cycle", 32'(obs_cyc[0]), 32'(c0 + 1));
      check("tp_span",        32'(obs_cyc[15] - obs_cyc[0]), 32'd15);
      for (int i = 0; i < 16; i++)
        check($sformatf("tp_data%0d", i), 32'(obs[i].d), 32'(8'h40 + i));
    end

    // ---------------- out-of-range select on the 3-input instance ----------
    check("oor_err_before", 32'(b3.err_o), 32'd0);
    b3.inp_sel_i   = 2'd3;
    b3.inp_valid_i = 3'b111;
    b3.inp_last_i  = 3'b111;
    for (int i = 0; i < 3; i++) b3.inp_data_i[i] = data_t'(8'hC0 + i);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("oor_ready%0d", i), 32'(b3.inp_ready_o), 32'd0);
      check($sformatf("oor_valid%0d", i), 32'(b3.oup_valid_o), 32'd0);
      check($sformatf("oor_err%0d", i),   32'(b3.err_o),       32'(EXP_ERR));
    end
    b3.inp_sel_i   = 2'd0;
    b3.inp_valid_i = 3'b000;
    repeat (2) tick();
    check("oor_err_sticky", 32'(b3.err_o), 32'(EXP_ERR));

    // ---------------- randomized traffic ----------------
    for (int c = 0; c < 600; c++) begin
      b4.inp_sel_i = 2'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) begin
        b4.inp_data_i[i]  = 8'($urandom);
        b4.inp_last_i[i]  = ($urandom_range(0, 2) == 0);
        b4.inp_valid_i[i] = ($urandom_range(0, 9) < 7);
      end
      b4.oup_ready_i = ($urandom_range(0, 3) != 0);
      tick();
    end
    clear_inputs();
    b4.oup_ready_i = 1'b1;
    repeat (3) tick();

    // ---------------- reset mid-packet ----------------
    b4.inp_sel_i = 2'd2;
    drive_beat(2, 8'h50, 1'b0);
    tick();
    drive_beat(2, 8'h51, 1'b0);
    tick();
    check("mid_locked_before", 32'(b4.locked_o), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_locked",   32'(b4.locked_o),    32'd0);
    check("mid_valid",    32'(b4.oup_valid_o), 32'd0);
    check("mid_lock_sel", 32'(b4.lock_sel_o),  32'd0);
    check("mid_err3",     32'(b3.err_o),       32'd0);
    owner = -1;
    q.delete();
    rst_n = 1'b1;
    drive_beat(2, 8'h52, 1'b0);
    b4.inp_sel_i = 2'd0;
    drive_beat(0, 8'h77, 1'b1);
    tick();
    check("mid_new_valid",  32'(b4.oup_valid_o), 32'd1);
    check("mid_new_data",   32'(b4.oup_data_o),  32'h77);
    check("mid_new_locked", 32'(b4.locked_o),    32'd0);
    clear_inputs();
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_stream_mux_pkt
